// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: accepts one miss, fetches the 64 B line
// with a single INCR burst on the AXI read channels, assembles it and presents
// a one-cycle fill (or error) strobe to the cache arrays.
module icache_refill_ctrl #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int AXI_ID     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_valid,
    input  logic [ADDR_WIDTH-1:0]    miss_addr,
    output logic                     miss_ready,
    output logic [ID_WIDTH-1:0]      m_arid,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic [7:0]               m_arlen,
    output logic [2:0]               m_arsize,
    output logic [1:0]               m_arburst,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [ID_WIDTH-1:0]      m_rid,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    output logic                     fill_valid,
    output logic [5:0]               fill_index,
    output logic [ADDR_WIDTH-13:0]   fill_tag,
    output logic [511:0]             fill_data,
    output logic                     fill_error
);

    localparam int LINE_BITS = 512;
    localparam int BEATS     = LINE_BITS / DATA_WIDTH;
    localparam int CNT_W     = $clog2(BEATS);
    localparam int OFF_W     = 6;   // byte offset within a 64 B line
    localparam int IDX_W     = 6;   // 64 sets

    localparam logic [ID_WIDTH-1:0] LP_ID        = ID_WIDTH'(AXI_ID);
    localparam logic [CNT_W-1:0]    LP_LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_FILL
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [ADDR_WIDTH-OFF_W-1:0] r_line_addr;
    logic [CNT_W-1:0]            r_beat_cnt;
    logic                        r_err;

    logic w_capture;
    logic w_beat_fire;
    logic w_beat_last;
    logic w_beat_bad;
    logic w_unused_addr_lsbs;

    assign w_capture   = (r_state == S_IDLE) && miss_valid;
    assign w_beat_fire = (r_state == S_DATA) && m_rvalid;
    assign w_beat_last = (r_beat_cnt == LP_LAST_BEAT);
    // A beat is bad on an error response, a foreign ID, or rlast in the wrong place.
    assign w_beat_bad  = (m_rresp != 2'b00) || (m_rid != LP_ID) || (m_rlast != w_beat_last);

    // Byte offset is discarded: requests are always line aligned.
    assign w_unused_addr_lsbs = &{1'b0, miss_addr[OFF_W-1:0]};

    // Fixed burst shape: one full line per request.
    assign m_arid     = LP_ID;
    assign m_araddr   = {r_line_addr, {OFF_W{1'b0}}};
    assign m_arlen    = 8'(BEATS - 1);
    assign m_arsize   = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst  = 2'b01;
    assign fill_index = r_line_addr[IDX_W-1:0];
    assign fill_tag   = r_line_addr[ADDR_WIDTH-OFF_W-1:IDX_W];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/strobe outputs, all decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        miss_ready   = 1'b0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        fill_valid   = 1'b0;
        fill_error   = 1'b0;
        case (r_state)
            S_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                m_rready = 1'b1;
                // The beat count, not rlast, decides when the line is complete.
                if (m_rvalid && w_beat_last) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                fill_valid   = !r_err;
                fill_error   = r_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Miss capture, beat counting and sticky error tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_addr <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else if (w_capture) begin
            r_line_addr <= miss_addr[ADDR_WIDTH-1:OFF_W];
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else if (w_beat_fire) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_beat_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // One data slot per beat position; the assembled slots drive fill_data directly.
    genvar gi;
    for (gi = 0; gi < BEATS; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] r_slot;

        // Capture the beat whose position matches this slot.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_slot <= '0;
            end else if (w_beat_fire && (r_beat_cnt == CNT_W'(gi))) begin
                r_slot <= m_rdata;
            end
        end

        assign fill_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: a transaction-level model of the
// refill (queue of received beats, line/err computed from the whole queue) is
// compared against the DUT every cycle, plus literal checks on directed cases.
module tb_icache_refill_ctrl;

    logic          clk;
    logic          reset;
    logic          miss_valid;
    logic [63:0]   miss_addr;
    logic          miss_ready;
    logic [12:0]   m_arid;
    logic [63:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [12:0]   m_rid;
    logic [63:0]   m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic          fill_valid;
    logic [5:0]    fill_index;
    logic [51:0]   fill_tag;
    logic [511:0]  fill_data;
    logic          fill_error;

    icache_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .m_arid     (m_arid),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rid      (m_rid),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .fill_valid (fill_valid),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .fill_error (fill_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int txn_no  = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [12:0] id;
        logic        last;
    } beat_t;

    beat_t        mdl_q[$];
    bit           mdl_busy;     // a miss has been accepted and not yet completed
    bit           mdl_ar;       // its address request has been accepted
    bit           mdl_fill;     // all eight beats received: this is the fill cycle
    bit           mdl_err;
    logic [63:0]  mdl_addr;
    logic [511:0] mdl_line;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mdl_busy = 0; mdl_ar = 0; mdl_fill = 0; mdl_err = 0;
                mdl_addr = '0; mdl_line = '0;
                mdl_q.delete();
            end else if (mdl_fill) begin
                mdl_fill = 0;
                mdl_busy = 0;
            end else if (!mdl_busy) begin
                if (miss_valid) begin
                    mdl_busy = 1;
                    mdl_ar   = 0;
                    mdl_addr = miss_addr;
                    mdl_q.delete();
                end
            end else if (!mdl_ar) begin
                if (m_arready) mdl_ar = 1;
            end else if (m_rvalid) begin
                mdl_q.push_back('{data: m_rdata, resp: m_rresp, id: m_rid, last: m_rlast});
                if (mdl_q.size() == 8) begin
                    mdl_fill = 1;
                    mdl_err  = 0;
                    for (int k = 0; k < 8; k++) begin
                        mdl_line[64*k +: 64] = mdl_q[k].data;
                        if (mdl_q[k].resp != 2'b00 || mdl_q[k].id != 13'd0 ||
                            mdl_q[k].last != (k == 7))
                            mdl_err = 1;
                    end
                end
            end
        end
    end

    // Compare DUT against the model once per cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("miss_ready", miss_ready, !mdl_busy);
                chk("arvalid", m_arvalid, mdl_busy && !mdl_ar && !mdl_fill);
                chk("rready", m_rready, mdl_busy && mdl_ar && !mdl_fill);
                chk("fill_valid", fill_valid, mdl_fill && !mdl_err);
                chk("fill_error", fill_error, mdl_fill && mdl_err);
                chk("araddr", m_araddr, {mdl_addr[63:6], 6'b0});
                chk("arid", m_arid, 13'd0);
                chk("arlen", m_arlen, 8'd7);
                chk("arsize", m_arsize, 3'd3);
                chk("arburst", m_arburst, 2'b01);
                chk("fill_index", fill_index, mdl_addr[11:6]);
                chk("fill_tag", fill_tag, mdl_addr[63:12]);
                if (!mdl_busy || mdl_fill) chk("fill_data", fill_data, mdl_line);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rid = 0; m_rdata = 0;
    endtask

    // One complete miss: request, AR handshake, 8 beats, fill. last_pos is the beat
    // index carrying rlast (8 = never). Optional reset abort in ADDR or DATA.
    task automatic run_miss(input logic [63:0] addr, input int ar_delay, input int rv_mode,
                            input bit fixed_pat, input int bad_resp_beat, input int bad_id_beat,
                            input int last_pos, input int abort_beat, input int abort_cyc,
                            output int cycles);
        logic [63:0] dat [8];
        int  n, beat, cyc;
        bit  ar_done, exp_err;
        for (int k = 0; k < 8; k++) dat[k] = fixed_pat ? 64'h11 * (k + 1) : {$urandom, $urandom};
        exp_err = (bad_resp_beat >= 0 && bad_resp_beat < 8) || (bad_id_beat >= 0 && bad_id_beat < 8) ||
                  (last_pos != 7);
        txn_no++;
        @(negedge clk);
        miss_valid = 1;
        miss_addr  = addr;
        n = 0;
        while (!miss_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!miss_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            miss_valid = 0;
            cycles = -1;
            return;
        end
        @(negedge clk);
        miss_valid = 0;
        miss_addr  = {$urandom, $urandom};
        beat = 0; cyc = 0; ar_done = 0;
        while (beat < 8 && cyc < 300) begin
            if ((abort_beat >= 0 && ar_done && beat == abort_beat) || (abort_cyc >= 0 && cyc == abort_cyc)) begin
                #3 reset = 0;
                #1;
                chk("rst_miss_ready", miss_ready, 1'b1);
                chk("rst_arvalid", m_arvalid, 1'b0);
                chk("rst_rready", m_rready, 1'b0);
                chk("rst_fill_valid", fill_valid, 1'b0);
                chk("rst_fill_error", fill_error, 1'b0);
                chk("rst_fill_data", fill_data, 512'd0);
                chk("rst_fill_index", fill_index, 6'd0);
                idle_inputs();
                @(negedge clk);
                #3 reset = 1;
                @(negedge clk);
                $display("txn %0d addr=%016h aborted by reset at beat %0d cycle %0d", txn_no, addr, beat, cyc);
                cycles = -1;
                return;
            end
            m_arready = !ar_done && (cyc >= ar_delay);
            case (rv_mode)
                0:       m_rvalid = 1;
                1:       m_rvalid = (cyc % 2 == 0);
                default: m_rvalid = 1'($urandom_range(0, 1));
            endcase
            m_rdata = dat[beat];
            m_rresp = (beat == bad_resp_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
            m_rid   = (beat == bad_id_beat) ? 13'h5 : 13'h0;
            m_rlast = (beat == last_pos);
            if (m_arvalid && m_arready) ar_done = 1;
            if (m_rvalid && m_rready) beat++;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        cycles = cyc;
        if (beat < 8) begin
            chk("burst_timeout", 1'b0, 1'b1);
            return;
        end
        // Now in the fill cycle.
        chk("txn_fill_valid", fill_valid, !exp_err);
        chk("txn_fill_error", fill_error, exp_err);
        $display("txn %0d addr=%016h ar_delay=%0d rv_mode=%0d err_expected=%0d cycles=%0d fill_valid=%0d fill_error=%0d",
                 txn_no, addr, ar_delay, rv_mode, exp_err, cyc + 1, fill_valid, fill_error);
        @(negedge clk);
        chk("txn_pulse_end", {fill_valid, fill_error}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fault, ar_delay, rv_mode, bad_resp, bad_id, last_pos;
        logic [63:0] addr;
        reset = 1; miss_valid = 0; miss_addr = '0;
        idle_inputs();
        #1 reset = 0;
        #1;
        chk("init_miss_ready", miss_ready, 1'b1);
        chk("init_arvalid", m_arvalid, 1'b0);
        chk("init_rready", m_rready, 1'b0);
        chk("init_fill", {fill_valid, fill_error}, 2'b00);
        chk_en = 1;
        #26 reset = 1;

        // Directed: clean refill, arready immediate, back-to-back beats.
        run_miss(64'h0000_0000_0001_2345, 0, 0, 1, -1, -1, 7, -1, -1, cyc);
        chk("t2_latency", cyc + 1, 10);
        chk("t2_araddr", m_araddr, 64'h12340);
        chk("t2_arlen", m_arlen, 8'd7);
        chk("t2_index", fill_index, 6'h0D);
        chk("t2_tag", fill_tag, 52'h12);
        chk("t2_data_lo", fill_data[63:0], 64'h11);
        chk("t2_data_hi", fill_data[511:448], 64'h88);

        // Slow AR handshake with toggling rvalid.
        run_miss(64'h0000_00AB_CDEF_1234, 5, 1, 0, -1, -1, 7, -1, -1, cyc);
        // Error response on beat 3.
        run_miss(64'h0000_0000_0004_0000, 0, 0, 0, 3, -1, 7, -1, -1, cyc);
        // Early rlast, then a clean refill.
        run_miss(64'h0000_0000_0005_0040, 0, 0, 0, -1, -1, 5, -1, -1, cyc);
        run_miss(64'h0000_0000_0005_0080, 1, 0, 0, -1, -1, 7, -1, -1, cyc);
        // Wrong ID, and missing rlast on the final beat.
        run_miss(64'h0000_0000_0006_0000, 0, 2, 0, -1, 2, 7, -1, -1, cyc);
        run_miss(64'h0000_0000_0007_0000, 0, 0, 0, -1, -1, 8, -1, -1, cyc);
        // Reset during DATA beat 4, then during ADDR; then a clean refill.
        run_miss(64'h0000_0000_0008_0FC0, 0, 0, 0, -1, -1, 7, 4, -1, cyc);
        repeat (3) @(negedge clk);
        run_miss(64'h0000_0000_0009_0000, 10, 0, 0, -1, -1, 7, -1, 2, cyc);
        run_miss(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 0, -1, -1, 7, -1, -1, cyc);
        chk("allones_index", fill_index, 6'h3F);
        chk("allones_tag", fill_tag, 52'hF_FFFF_FFFF_FFFF);

        // Randomized refills.
        for (int t = 0; t < 24; t++) begin
            addr     = {$urandom, $urandom};
            ar_delay = $urandom_range(0, 4);
            rv_mode  = $urandom_range(0, 2);
            fault    = $urandom_range(0, 5);
            bad_resp = (fault == 3) ? int'($urandom_range(0, 7)) : -1;
            bad_id   = (fault == 4) ? int'($urandom_range(0, 7)) : -1;
            last_pos = 7;
            if (fault == 5) begin
                last_pos = $urandom_range(0, 7);
                if (last_pos == 7) last_pos = 8;
            end
            run_miss(addr, ar_delay, rv_mode, 0, bad_resp, bad_id, last_pos, -1, -1, cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
